// File: rtl/bus16_arbiter.sv
// rtl/bus16_arbiter.sv - two-master round-robin arbiter for the 16-bit register bus
// Optional read timeout enabled by defining BUS16_ARB_TIMEOUT_EN.
module bus16_arbiter #(
  parameter int          TIMEOUT_CLKS = 1024,
  parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD
) (
  input  logic        i_Bus_Clk,
  input  logic        i_Bus_Rst_L,
  input  logic        i_M0_CS,
  input  logic        i_M0_Wr_Rd_n,
  input  logic [15:0] i_M0_Addr8,
  input  logic [15:0] i_M0_Wr_Data,
  output logic [15:0] o_M0_Rd_Data,
  output logic        o_M0_Rd_DV,
  output logic        o_M0_Busy,
  output logic        o_M0_Drop,
  input  logic        i_M1_CS,
  input  logic        i_M1_Wr_Rd_n,
  input  logic [15:0] i_M1_Addr8,
  input  logic [15:0] i_M1_Wr_Data,
  output logic [15:0] o_M1_Rd_Data,
  output logic        o_M1_Rd_DV,
  output logic        o_M1_Busy,
  output logic        o_M1_Drop,
  output logic        o_Bus_CS,
  output logic        o_Bus_Wr_Rd_n,
  output logic [15:0] o_Bus_Addr8,
  output logic [15:0] o_Bus_Wr_Data,
  input  logic [15:0] i_Bus_Rd_Data,
  input  logic        i_Bus_Rd_DV,
  output logic        o_Timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t      state;
  logic [1:0]  cs;
  logic [1:0]  pending;
  logic [1:0]  drop;
  logic [1:0]  rd_dv;
  logic [15:0] rd_data [2];
  logic        slot_wr [2];
  logic [15:0] slot_addr [2];
  logic [15:0] slot_data [2];
  logic        grant;
  logic        next_grant;
  logic        rr_last;

  assign cs = {i_M1_CS, i_M0_CS};

  // Slots only load while their master is idle, so the other master's traffic never touches them.
  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      drop         <= '0;
      slot_wr[0]   <= 1'b0;
      slot_wr[1]   <= 1'b0;
      slot_addr[0] <= '0;
      slot_addr[1] <= '0;
      slot_data[0] <= '0;
      slot_data[1] <= '0;
    end else begin
      drop <= cs & pending;
      if (i_M0_CS && !pending[0]) begin
        slot_wr[0]   <= i_M0_Wr_Rd_n;
        slot_addr[0] <= i_M0_Addr8;
        slot_data[0] <= i_M0_Wr_Data;
      end
      if (i_M1_CS && !pending[1]) begin
        slot_wr[1]   <= i_M1_Wr_Rd_n;
        slot_addr[1] <= i_M1_Addr8;
        slot_data[1] <= i_M1_Wr_Data;
      end
    end
  end

  // rr_last resets to 1 so the first contended grant goes to M0.
  always_comb begin
    next_grant = 1'b0;
    if (pending == 2'b11) next_grant = ~rr_last;
    else                  next_grant = pending[1];
  end

`ifdef BUS16_ARB_TIMEOUT_EN
  localparam logic [15:0] TC_LAST = 16'(TIMEOUT_CLKS - 1);
  logic [15:0] wait_cnt;
  logic        timeout_q;
  assign o_Timeout = timeout_q;
`else
  assign o_Timeout = 1'b0;
`endif

  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      state         <= IDLE;
      pending       <= '0;
      grant         <= 1'b0;
      rr_last       <= 1'b1;
      rd_dv         <= '0;
      rd_data[0]    <= '0;
      rd_data[1]    <= '0;
      o_Bus_CS      <= 1'b0;
      o_Bus_Wr_Rd_n <= 1'b0;
      o_Bus_Addr8   <= '0;
      o_Bus_Wr_Data <= '0;
`ifdef BUS16_ARB_TIMEOUT_EN
      wait_cnt      <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      o_Bus_CS <= 1'b0;
      rd_dv    <= '0;
`ifdef BUS16_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      // Set and clear of one pending bit never coincide: capture needs it clear, completion needs it set.
      for (int m = 0; m < 2; m++) begin
        if (cs[m] && !pending[m]) pending[m] <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (|pending) begin
            grant         <= next_grant;
            o_Bus_CS      <= 1'b1;
            o_Bus_Wr_Rd_n <= slot_wr[next_grant];
            o_Bus_Addr8   <= slot_addr[next_grant];
            o_Bus_Wr_Data <= slot_data[next_grant];
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (o_Bus_Wr_Rd_n) begin
            pending[grant] <= 1'b0;
            rr_last        <= grant;
            state          <= IDLE;
          end else begin
`ifdef BUS16_ARB_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            state <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (i_Bus_Rd_DV) begin
            rd_data[grant] <= i_Bus_Rd_Data;
            rd_dv[grant]   <= 1'b1;
            pending[grant] <= 1'b0;
            rr_last        <= grant;
            state          <= IDLE;
          end
`ifdef BUS16_ARB_TIMEOUT_EN
          else if (wait_cnt == TC_LAST) begin
            rd_data[grant] <= TIMEOUT_DATA;
            rd_dv[grant]   <= 1'b1;
            timeout_q      <= 1'b1;
            pending[grant] <= 1'b0;
            rr_last        <= grant;
            state          <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_M0_Busy    = pending[0];
  assign o_M1_Busy    = pending[1];
  assign o_M0_Drop    = drop[0];
  assign o_M1_Drop    = drop[1];
  assign o_M0_Rd_DV   = rd_dv[0];
  assign o_M1_Rd_DV   = rd_dv[1];
  assign o_M0_Rd_Data = rd_data[0];
  assign o_M1_Rd_Data = rd_data[1];

endmodule

// File: tb/tb_bus16_arbiter.sv
// tb/tb_bus16_arbiter.sv - directed self-checking bench for bus16_arbiter
module tb_bus16_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cs = 0, m0_wr = 0, m1_cs = 0, m1_wr = 0;
  logic [15:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [15:0] m0_rdata, m1_rdata;
  logic        m0_rdv, m0_busy, m0_drop, m1_rdv, m1_busy, m1_drop;
  logic        bus_cs, bus_wr, timeout;
  logic [15:0] bus_addr, bus_wdata;
  logic [15:0] bus_rdata = 0;
  logic        bus_rdv = 0;
  int          checks = 0;
  int          errors = 0;
  int          n;

  always #5 clk = ~clk;

  bus16_arbiter #(.TIMEOUT_CLKS(16), .TIMEOUT_DATA(16'hDEAD)) dut (
    .i_Bus_Clk(clk), .i_Bus_Rst_L(rst_n),
    .i_M0_CS(m0_cs), .i_M0_Wr_Rd_n(m0_wr), .i_M0_Addr8(m0_addr), .i_M0_Wr_Data(m0_wdata),
    .o_M0_Rd_Data(m0_rdata), .o_M0_Rd_DV(m0_rdv), .o_M0_Busy(m0_busy), .o_M0_Drop(m0_drop),
    .i_M1_CS(m1_cs), .i_M1_Wr_Rd_n(m1_wr), .i_M1_Addr8(m1_addr), .i_M1_Wr_Data(m1_wdata),
    .o_M1_Rd_Data(m1_rdata), .o_M1_Rd_DV(m1_rdv), .o_M1_Busy(m1_busy), .o_M1_Drop(m1_drop),
    .o_Bus_CS(bus_cs), .o_Bus_Wr_Rd_n(bus_wr), .o_Bus_Addr8(bus_addr), .o_Bus_Wr_Data(bus_wdata),
    .i_Bus_Rd_Data(bus_rdata), .i_Bus_Rd_DV(bus_rdv), .o_Timeout(timeout)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    tick();
    check_val("rst_bus_cs", 32'(bus_cs), 0);
    check_val("rst_busy", 32'({m1_busy, m0_busy}), 0);
    check_val("rst_rdv", 32'({m1_rdv, m0_rdv}), 0);
    check_val("rst_addr", 32'(bus_addr), 0);
    check_val("rst_timeout", 32'(timeout), 0);
    rst_n = 1'b1;
    tick();

    // 1: M0 write, uncontended
    m0_cs = 1; m0_wr = 1; m0_addr = 16'h005A; m0_wdata = 16'h0006;
    tick(); m0_cs = 0;
    check_val("t1_busy_n1", 32'(m0_busy), 1);
    check_val("t1_cs_n1", 32'(bus_cs), 0);
    tick();
    check_val("t1_cs_n2", 32'(bus_cs), 1);
    check_val("t1_addr", 32'(bus_addr), 32'h005A);
    check_val("t1_data", 32'(bus_wdata), 32'h0006);
    check_val("t1_wr", 32'(bus_wr), 1);
    tick();
    check_val("t1_busy_n3", 32'(m0_busy), 0);
    check_val("t1_cs_n3", 32'(bus_cs), 0);
    check_val("t1_addr_hold", 32'(bus_addr), 32'h005A);

    // 2: M1 read, slave answers 3 cycles after CS
    m1_cs = 1; m1_wr = 0; m1_addr = 16'h0014;
    tick(); m1_cs = 0;
    tick();
    check_val("t2_cs", 32'(bus_cs), 1);
    check_val("t2_addr", 32'(bus_addr), 32'h0014);
    check_val("t2_wr", 32'(bus_wr), 0);
    tick(); tick(); tick();
    bus_rdv = 1; bus_rdata = 16'hBEEF;
    check_val("t2_rdv_early", 32'(m1_rdv), 0);
    tick(); bus_rdv = 0;
    check_val("t2_rdv", 32'(m1_rdv), 1);
    check_val("t2_rdata", 32'(m1_rdata), 32'hBEEF);
    check_val("t2_m0_rdv", 32'(m0_rdv), 0);
    check_val("t2_busy", 32'(m1_busy), 0);
    tick();
    check_val("t2_rdv_pulse", 32'(m1_rdv), 0);
    check_val("t2_m0_rdv_after", 32'(m0_rdv), 0);

    // 3: simultaneous requests after reset, then after an M0-only transfer
    do_reset();
    m0_cs = 1; m0_wr = 1; m0_addr = 16'h0100;
    m1_cs = 1; m1_wr = 1; m1_addr = 16'h0200;
    tick(); m0_cs = 0; m1_cs = 0;
    tick();
    check_val("t3_first", 32'({bus_cs, bus_addr}), 32'h10100);
    tick();
    check_val("t3_gap", 32'(bus_cs), 0);
    tick();
    check_val("t3_second", 32'({bus_cs, bus_addr}), 32'h10200);
    tick();
    m0_cs = 1; m0_addr = 16'h0300;
    tick(); m0_cs = 0;
    tick();
    check_val("t3_solo", 32'({bus_cs, bus_addr}), 32'h10300);
    tick();
    m0_cs = 1; m0_addr = 16'h0310;
    m1_cs = 1; m1_addr = 16'h0210;
    tick(); m0_cs = 0; m1_cs = 0;
    tick();
    check_val("t3_rr_first", 32'({bus_cs, bus_addr}), 32'h10210);
    tick(); tick();
    check_val("t3_rr_second", 32'({bus_cs, bus_addr}), 32'h10310);
    tick(); tick();

    // 4: second CS while busy is dropped
    m0_cs = 1; m0_wr = 1; m0_addr = 16'h0040; m0_wdata = 16'h1111;
    tick();
    check_val("t4_busy", 32'(m0_busy), 1);
    m0_addr = 16'h0041; m0_wdata = 16'h2222;
    tick(); m0_cs = 0;
    check_val("t4_drop", 32'(m0_drop), 1);
    check_val("t4_cs", 32'(bus_cs), 1);
    check_val("t4_addr", 32'(bus_addr), 32'h0040);
    check_val("t4_data", 32'(bus_wdata), 32'h1111);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n += int'(bus_cs);
    end
    check_val("t4_single_cs", 32'(n), 0);
    check_val("t4_drop_pulse", 32'(m0_drop), 0);
    check_val("t4_idle", 32'(m0_busy), 0);

    // 5: read with no slave answer
    m0_cs = 1; m0_wr = 0; m0_addr = 16'h0077;
    tick(); m0_cs = 0;
    tick();
    check_val("t5_cs", 32'({bus_cs, bus_addr}), 32'h10077);
`ifdef BUS16_ARB_TIMEOUT_EN
    repeat (16) tick();
    check_val("t5_pre_to", 32'({timeout, m0_rdv}), 0);
    tick();
    check_val("t5_rdv", 32'(m0_rdv), 1);
    check_val("t5_dead", 32'(m0_rdata), 32'hDEAD);
    check_val("t5_timeout", 32'(timeout), 1);
    check_val("t5_busy", 32'(m0_busy), 0);
    bus_rdv = 1; bus_rdata = 16'h1234;
    tick(); bus_rdv = 0;
    check_val("t5_late", 32'({timeout, m0_rdv}), 0);
    check_val("t5_data_kept", 32'(m0_rdata), 32'hDEAD);
    m0_cs = 1; m0_wr = 0; m0_addr = 16'h0077;
    tick(); m0_cs = 0;
    tick(); tick();
`else
    repeat (30) tick();
    check_val("t5_busy_hold", 32'(m0_busy), 1);
    check_val("t5_no_rdv", 32'({timeout, m0_rdv}), 0);
`endif

    // 6: reset while waiting for read data
    check_val("t6_waiting", 32'(m0_busy), 1);
    rst_n = 1'b0;
    #1;
    check_val("t6_busy", 32'({m1_busy, m0_busy}), 0);
    check_val("t6_addr", 32'(bus_addr), 0);
    check_val("t6_rdata", 32'(m0_rdata), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    bus_rdv = 1; bus_rdata = 16'h5555;
    tick(); bus_rdv = 0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      n += int'(m0_rdv) + int'(m1_rdv);
      tick();
    end
    check_val("t6_no_rdv", 32'(n), 0);
    m1_cs = 1; m1_wr = 1; m1_addr = 16'h0ABC; m1_wdata = 16'h00CD;
    tick(); m1_cs = 0;
    tick();
    check_val("t6_new_cs", 32'({bus_cs, bus_addr}), 32'h10ABC);
    tick();
    check_val("t6_new_done", 32'(m1_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
